bcd_convert_ctrl: RTL and testbench
===================================

# bcd_convert_ctrl

Sequential binary-to-BCD conversion controller. Accepts one unsigned binary word over a valid/ready handshake, runs the shift-add-3 (double-dabble) sequence one bit per clock on an internal register file, and presents the packed BCD result over a second valid/ready handshake. Intended as the clocked, width-scalable replacement for the combinational binary-to-BCD converter wherever the binary source or BCD consumer (display driver, UART formatter) is itself clocked.

## Interface
- BIN, 8, binary input width in bits (≥ 2)
- DIGITS, 3, BCD output digits; must satisfy 10^DIGITS > 2^BIN − 1 (BIN=8 → 3, BIN=4 → 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; one clock domain only
- in_valid  input  1  binary is valid
- in_ready  output  1  controller can accept a word
- binary  input  BIN  unsigned value to convert
- out_valid  output  1  BCD holds a finished result
- out_ready  input  1  consumer takes the result
- BCD  output  4*DIGITS  packed result, digit 0 (units) in bits [3:0]
- busy  output  1  conversion in progress (state SHIFT)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid && in_ready at a rising edge: load shift register with binary, clear digit register, load bit counter with BIN−1, go to SHIFT.
- SHIFT: each cycle, in every digit ≥ 5 add 3 (4-bit, no carry out of a digit), then shift {digits, shift reg} left by one, MSB of the shift register entering digit 0 bit 0. Counter decrements; the cycle with counter = 0 is the last shift, transitioning to DONE.
- DONE: out_valid=1, BCD drives digit register. On out_valid && out_ready go to IDLE.
- Add-3 correction uses pre-shift digit values only; corrections in one cycle are independent per digit.
- BCD is registered; it changes only on the final SHIFT edge and holds unchanged through DONE and the subsequent IDLE until the next final shift.
- in_valid outside IDLE is ignored; binary is sampled only at the accept edge, later changes have no effect.
- out_ready outside DONE is ignored.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, in_ready=1 after release, out_valid=0, busy=0, BCD=0, counter=0, shift/digit registers=0. Asserting reset mid-SHIFT or in DONE aborts the conversion; the result is discarded.
- While reset=0, in_ready=0 (no accept during reset).
- Accept at edge T0 → busy=1 from T0, SHIFT occupies edges T1..TBIN, out_valid=1 from edge TBIN (latency BIN cycles accept-to-valid).
- out_valid && out_ready at edge Tk → out_valid=0, in_ready=1 from Tk; next accept earliest at Tk+1. Minimum period: BIN+2 cycles per conversion.
- out_ready held high through DONE → DONE lasts exactly one cycle.
- in_ready, out_valid and busy are decoded from registered state only; no combinational path from in_valid/out_ready to any output.

## Test plan
- Reset then BIN=8, accept binary=0 → out_valid exactly 8 cycles after accept, BCD=12'h000; busy high for 8 cycles.
- Accept binary=8'd255 with out_ready=1 → BCD=12'h255, out_valid high for exactly one cycle, in_ready returns next cycle.
- Back-to-back: in_valid held high, binary=8'd9 then 8'd10 → results 12'h009 then 12'h010, second accept exactly 1 cycle after first out handshake; exhaustive sweep 0–255 all match reference decimal.
- Backpressure: binary=8'd99, out_ready=0 for 5 cycles after out_valid → BCD stays 12'h099, out_valid stays 1, in_ready stays 0, new in_valid ignored; out_ready=1 → IDLE.
- Reset asserted on 4th SHIFT cycle of binary=8'd200 → out_valid=0, BCD=0 immediately (asynchronous), no result emitted after release; next conversion of 8'd37 gives 12'h037.
- Parameter BIN=4, DIGITS=2: sweep 0–15 → 10 gives 8'h10, 15 gives 8'h15, latency 4 cycles.

Source files
------------

// File: rtl/bcd_convert_ctrl.sv
// bcd_convert_ctrl: sequential binary-to-BCD converter (shift-add-3, one bit
// per clock) with a valid/ready handshake on the input and on the output.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready, out_valid and busy come from registered state only.
// in_ready is additionally held low while reset is asserted. in_valid is
// ignored outside IDLE, and out_ready is ignored outside DONE.
module bcd_convert_ctrl #(
  parameter int BIN    = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN-1:0]        binary,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(BIN);
  localparam int DW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [BIN-1:0]  sreg_q;
  logic [DW-1:0]   dig_q;
  logic [DW-1:0]   bcd_q;
  logic [DW-1:0]   adj;
  logic [DW-1:0]   shifted;
  logic            accept;

  assign in_ready  = reset && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_SHIFT);
  assign BCD       = bcd_q;
  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready;

  // Add-3 on every digit >= 5 (from pre-shift values), then shift one bit in.
  always_comb begin
    adj = dig_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (dig_q[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = dig_q[4*d +: 4] + 4'd3;
      end
    end
    shifted = {adj[DW-2:0], sreg_q[BIN-1]};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load on accept, shift while converting, publish on last shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      dig_q  <= '0;
      bcd_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sreg_q <= binary;
            dig_q  <= '0;
            cnt_q  <= CW'(BIN - 1);
          end
        end
        S_SHIFT: begin
          dig_q  <= shifted;
          sreg_q <= {sreg_q[BIN-2:0], 1'b0};
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            bcd_q <= shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed bench for bcd_convert_ctrl (BIN=8/DIGITS=3 and BIN=4/DIGITS=2).
module tb_bcd_convert_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  binary;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;
  logic        busy;
  logic [1:0]  dbg_state;

  logic        in_valid4;
  logic        in_ready4;
  logic [3:0]  bin4;
  logic        out_valid4;
  logic        out_ready4;
  logic [7:0]  bcd4;
  logic        busy4;
  logic [1:0]  dbg_state4;

  int checks;
  int failures;

  logic [11:0] exp_q[$];
  logic [7:0]  exp4_q[$];

  bcd_convert_ctrl #(.BIN(8), .DIGITS(3)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .binary(binary), .out_valid(out_valid), .out_ready(out_ready),
    .BCD(bcd), .busy(busy), .dbg_state(dbg_state)
  );

  bcd_convert_ctrl #(.BIN(4), .DIGITS(2)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .binary(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .BCD(bcd4), .busy(busy4), .dbg_state(dbg_state4)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present v on the 8-bit unit and wait (bounded) for the accept edge.
  task automatic do_accept(input logic [7:0] v);
    int w;
    w = 0;
    in_valid = 1'b1;
    binary   = v;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    exp_q.push_back(ref_bcd(v));
    #1;
  endtask

  // Wait (bounded) for out_valid, checking latency, busy span and result.
  task automatic wait_out(input int exp_lat);
    int lat;
    int bcnt;
    logic [11:0] e;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && busy) bcnt++;
    end
    chk("latency", lat, exp_lat);
    chk("busy_cycles", bcnt, exp_lat);
    chk("busy_low_in_done", busy, 0);
    chk("sb_pending", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("bcd_result", bcd, e);
    end
  endtask

  // Clock/reset, then directed steps.
  initial begin
    int ov_cnt;
    int w;
    int lat;
    logic [7:0] e4;
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    binary     = '0;
    out_ready  = 1'b0;
    in_valid4  = 1'b0;
    bin4       = '0;
    out_ready4 = 1'b0;

    // Reset state.
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bcd", bcd, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_state", dbg_state, 0);

    // Zero: latency and busy span.
    out_ready = 1'b1;
    do_accept(8'd0);
    in_valid = 1'b0;
    wait_out(8);

    // 255 with out_ready high: one-cycle DONE, BCD held in IDLE.
    do_accept(8'd255);
    in_valid = 1'b0;
    wait_out(8);
    @(posedge clk); #1;
    chk("ff_out_valid_drop", out_valid, 0);
    chk("ff_in_ready_back", in_ready, 1);
    chk("ff_bcd_hold", bcd, ref_bcd(255));

    // Back-to-back with in_valid held high.
    do_accept(8'd9);
    binary = 8'd10;
    wait_out(8);
    @(posedge clk); #1;
    chk("b2b_out_valid_drop", out_valid, 0);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    exp_q.push_back(ref_bcd(10));
    #1;
    chk("b2b_second_accept", busy, 1);
    in_valid = 1'b0;
    wait_out(8);
    @(posedge clk); #1;
    chk("b2b_done_one_cycle", out_valid, 0);

    // Backpressure on 99; in_valid during DONE ignored.
    out_ready = 1'b0;
    do_accept(8'd99);
    in_valid = 1'b0;
    wait_out(8);
    in_valid = 1'b1;
    binary   = 8'd123;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_bcd", bcd, ref_bcd(99));
      chk("bp_in_ready", in_ready, 0);
      chk("bp_state", dbg_state, 2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_bcd", bcd, ref_bcd(99));

    // Reset during the 4th shift of 200 aborts the conversion.
    do_accept(8'd200);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) ov_cnt++;
    end
    chk("abort_no_result", ov_cnt, 0);
    chk("abort_bcd_stays", bcd, 0);
    do_accept(8'd37);
    in_valid = 1'b0;
    wait_out(8);

    // Sweep 0..255.
    for (int v = 0; v < 256; v++) begin
      do_accept(8'(v));
      in_valid = 1'b0;
      wait_out(8);
    end

    // BIN=4 / DIGITS=2 sweep.
    out_ready4 = 1'b1;
    for (int v = 0; v < 16; v++) begin
      in_valid4 = 1'b1;
      bin4      = 4'(v);
      w = 0;
      while (!in_ready4 && w < 60) begin
        @(posedge clk); #1;
        w++;
      end
      chk("b4_accept_ready", in_ready4, 1);
      @(posedge clk);
      exp4_q.push_back(8'(ref_bcd(v)));
      #1;
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 60) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("b4_latency", lat, 4);
      chk("b4_sb_pending", exp4_q.size(), 1);
      if (exp4_q.size() != 0) begin
        e4 = exp4_q.pop_front();
        chk("b4_bcd", bcd4, e4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
